// File: rtl/uart_defs.sv
// Shared UART definitions: autobaud error causes and detector states.
package uart_defs;

  typedef enum logic [1:0] {
    TIMEOUT = 2'd0,
    JITTER  = 2'd1,
    FRAME   = 2'd2,
    RANGE   = 2'd3
  } AbdErr_t;

  typedef enum logic [2:0] {
    IDLE,
    ARM,
    WAIT_START,
    MEASURE,
    STOP_RISE,
    STOP_SAMPLE,
    DONE
  } AbdState_t;

endpackage

// File: rtl/uart_sync_edge.sv
// Two-flop synchronizer for an asynchronous idle-high line, plus rise/fall strobes.
module uart_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o,
  output logic rise_o,
  output logic fall_o
);

  logic s1_q, s2_q, prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q   <= 1'b1;
      s2_q   <= 1'b1;
      prev_q <= 1'b1;
    end else begin
      s1_q   <= d_i;
      s2_q   <= s1_q;
      prev_q <= s2_q;
    end
  end

  assign q_o    = s2_q;
  assign rise_o = s2_q & ~prev_q;
  assign fall_o = ~s2_q & prev_q;

endmodule

// File: rtl/uart_autobaud.sv
// Times a 0x55 sync character on RX and derives the UART oversampling divider.
module uart_autobaud
  import uart_defs::*;
#(
  parameter int unsigned CNT_W    = 24,
  parameter int unsigned OSR_LOG2 = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rx_i,
  input  logic        start_i,
  output logic        busy_o,
  output logic [31:0] divider_o,
  output logic        divider_valid_o,
  output logic        error_o,
  output logic [1:0]  err_cause_o
);

  localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);
  localparam logic [CNT_W:0]   ONE_W   = (CNT_W + 1)'(1);
  localparam logic [CNT_W:0]   RND_ADD = ONE_W << (2 + OSR_LOG2);

  logic line, rise, fall;

  uart_sync_edge u_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .d_i    (rx_i),
    .q_o    (line),
    .rise_o (rise),
    .fall_o (fall)
  );

  AbdState_t        state_q, state_d;
  AbdErr_t          cause_q, cause_d;
  logic [CNT_W-1:0] cnt_q, icnt_q, i0_q, t_q, rise_lim, samp_lim;
  logic [1:0]       nfall_q;
  logic [CNT_W:0]   interval, delta, rnd, div_w;
  logic             clr_meas, rst_icnt, store_i0, latch_t, set_err, set_div;
  logic             jitter_bad, cnt_sat, in_meas;

  assign interval   = {1'b0, icnt_q} + ONE_W;
  assign delta      = (interval >= {1'b0, i0_q}) ? interval - {1'b0, i0_q}
                                                 : {1'b0, i0_q} - interval;
  assign jitter_bad = delta > {3'b000, i0_q[CNT_W-1:2]};
  assign cnt_sat    = &cnt_q;
  assign rise_lim   = (t_q >> 3) + (t_q >> 5);
  assign samp_lim   = t_q >> 4;
  assign rnd        = {1'b0, t_q} + RND_ADD;
  assign div_w      = rnd >> (3 + OSR_LOG2);
  assign in_meas    = (state_q == MEASURE) || (state_q == STOP_RISE) || (state_q == STOP_SAMPLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    cause_d  = TIMEOUT;
    clr_meas = 1'b0;
    rst_icnt = 1'b0;
    store_i0 = 1'b0;
    latch_t  = 1'b0;
    set_err  = 1'b0;
    set_div  = 1'b0;
    case (state_q)
      IDLE:       if (start_i) state_d = ARM;
      ARM:        if (line) state_d = WAIT_START;
      WAIT_START: if (fall) begin
        state_d  = MEASURE;
        clr_meas = 1'b1;
      end
      MEASURE: begin
        if (cnt_sat) begin
          set_err = 1'b1;
          cause_d = TIMEOUT;
        end else if (fall) begin
          if (nfall_q != 2'd0 && jitter_bad) begin
            set_err = 1'b1;
            cause_d = JITTER;
          end else begin
            rst_icnt = 1'b1;
            store_i0 = (nfall_q == 2'd0);
            if (nfall_q == 2'd3) begin
              latch_t = 1'b1;
              state_d = STOP_RISE;
            end
          end
        end
      end
      STOP_RISE: begin
        if (cnt_sat) begin
          set_err = 1'b1;
          cause_d = TIMEOUT;
        end else if (fall) begin
          set_err = 1'b1;
          cause_d = FRAME;
        end else if (rise) begin
          rst_icnt = 1'b1;
          state_d  = STOP_SAMPLE;
        end else if (icnt_q >= rise_lim) begin
          set_err = 1'b1;
          cause_d = FRAME;
        end
      end
      STOP_SAMPLE: begin
        if (cnt_sat) begin
          set_err = 1'b1;
          cause_d = TIMEOUT;
        end else if (fall) begin
          set_err = 1'b1;
          cause_d = FRAME;
        end else if (icnt_q >= samp_lim) begin
          if (line) begin
            state_d = DONE;
          end else begin
            set_err = 1'b1;
            cause_d = FRAME;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
        if (div_w == '0) begin
          set_err = 1'b1;
          cause_d = RANGE;
        end else begin
          set_div = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (set_err) state_d = IDLE;
  end

  // icnt doubles as the stop-bit timer once the span T is latched
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q           <= '0;
      icnt_q          <= '0;
      nfall_q         <= '0;
      i0_q            <= '0;
      t_q             <= '0;
      cause_q         <= TIMEOUT;
      divider_o       <= '0;
      divider_valid_o <= 1'b0;
      error_o         <= 1'b0;
    end else begin
      if (clr_meas)     cnt_q <= '0;
      else if (in_meas) cnt_q <= cnt_q + ONE_C;
      if (clr_meas || rst_icnt) icnt_q <= '0;
      else if (in_meas)         icnt_q <= icnt_q + ONE_C;
      if (clr_meas)                              nfall_q <= '0;
      else if (rst_icnt && state_q == MEASURE)   nfall_q <= nfall_q + 2'd1;
      if (store_i0) i0_q <= interval[CNT_W-1:0];
      if (latch_t)  t_q  <= cnt_q + ONE_C;
      if (set_err)  cause_q <= cause_d;
      if (set_div)  divider_o <= 32'(div_w);
      divider_valid_o <= set_div;
      error_o         <= set_err;
    end
  end

  assign busy_o      = (state_q != IDLE);
  assign err_cause_o = cause_q;

endmodule

// File: tb/tb_uart_autobaud.sv
// Randomized bench for uart_autobaud against an edge-timing model of the sync character.
module tb_uart_autobaud;

  localparam int OSR = 4;

  logic        clk = 1'b0, rst_n = 1'b0, rx = 1'b1, start = 1'b0;
  logic        busy, valid, err, busy_t, valid_t, err_t;
  logic [31:0] div, div_t;
  logic [1:0]  cause, cause_t;

  uart_autobaud #(.CNT_W(24), .OSR_LOG2(OSR)) dut (
    .clk(clk), .rst_n(rst_n), .rx_i(rx), .start_i(start), .busy_o(busy),
    .divider_o(div), .divider_valid_o(valid), .error_o(err), .err_cause_o(cause));

  uart_autobaud #(.CNT_W(12), .OSR_LOG2(OSR)) dut_t (
    .clk(clk), .rst_n(rst_n), .rx_i(rx), .start_i(start), .busy_o(busy_t),
    .divider_o(div_t), .divider_valid_o(valid_t), .error_o(err_t), .err_cause_o(cause_t));

  always #5 clk = ~clk;

  int total = 0, bad = 0, exp_div = 0;
  int nval = 0, nerr = 0, nerr_t = 0, busy_bad = 0, both_hi = 0;
  int last_div = 0, last_cause = 0, last_cause_t = 0;

  always @(negedge clk) begin
    if (valid) begin nval++; last_div = int'(div); if (busy) busy_bad++; end
    if (err) begin nerr++; last_cause = int'(cause); if (busy) busy_bad++; end
    if (valid && err) both_hi++;
    if (err_t) begin nerr_t++; last_cause_t = int'(cause_t); end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Expected outcome from the falling-edge times of a 0x55 frame: -1 = success
  function automatic void model(input int dur[10], input bit stop_low, input int cnt_w,
                                output int kind, output int d);
    int st[11];
    int i0, ik, t, lim, dev;
    kind = -1;
    d = 0;
    st[0] = 0;
    for (int i = 0; i < 10; i++) st[i+1] = st[i] + dur[i];
    i0 = st[2] - st[0];
    for (int k = 1; k < 4; k++) begin
      ik  = st[2*k+2] - st[2*k];
      dev = (ik > i0) ? ik - i0 : i0 - ik;
      if (dev > i0 / 4) begin kind = 1; return; end
    end
    t = st[8];
    if (t >= (1 << cnt_w)) begin kind = 0; return; end
    lim = (t >> 3) + (t >> 5);
    if (stop_low || dur[8] > lim) begin kind = 2; return; end
    d = (t + (1 << (2 + OSR))) >> (3 + OSR);
    if (d == 0) kind = 3;
  endfunction

  function automatic void flat(input int b, output int dur[10]);
    for (int i = 0; i < 10; i++) dur[i] = b;
  endfunction

  task automatic arm();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (6) @(posedge clk);
    #1;
  endtask

  task automatic send(input int dur[10], input bit stop_low, input bit poke);
    logic [7:0] pat;
    pat = 8'h55;
    for (int i = 0; i < 10; i++) begin
      rx = (i == 0) ? 1'b0 : (i == 9) ? ~stop_low : pat[i-1];
      if (poke && i == 4) begin
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (dur[i] - 1) @(posedge clk);
      end else begin
        repeat (dur[i]) @(posedge clk);
      end
      #1;
    end
    rx = 1'b1;
  endtask

  task automatic run_frame(input string name, input int dur[10], input bit stop_low,
                           input bit do_arm, input bit poke);
    int kind, d, b_v, b_e, b_busy, b_both, waited;
    model(dur, stop_low, 24, kind, d);
    b_v = nval; b_e = nerr; b_busy = busy_bad; b_both = both_hi;
    if (do_arm) arm();
    send(dur, stop_low, poke);
    waited = 0;
    while ((nval + nerr) == (b_v + b_e) && waited < 4000) begin
      @(posedge clk);
      waited++;
    end
    repeat (4) @(posedge clk);
    #1;
    total++;
    if (waited >= 4000) begin
      bad++;
      $display("FAIL %s result_pulse: none within %0d cycles, required one", name, waited);
    end
    if (kind < 0) begin
      total++;
      if ((nval - b_v) !== 1 || (nerr - b_e) !== 0) begin
        bad++;
        $display("FAIL %s pulse_count: valid=%0d error=%0d, required valid=1 error=0",
                 name, nval - b_v, nerr - b_e);
      end
      total++;
      if (last_div !== d) begin
        bad++;
        $display("FAIL %s divider: got %0d, required %0d", name, last_div, d);
      end
      exp_div = d;
    end else begin
      total++;
      if ((nerr - b_e) !== 1 || (nval - b_v) !== 0) begin
        bad++;
        $display("FAIL %s pulse_count: valid=%0d error=%0d, required valid=0 error=1",
                 name, nval - b_v, nerr - b_e);
      end
      total++;
      if (last_cause !== kind) begin
        bad++;
        $display("FAIL %s err_cause: got %0d, required %0d", name, last_cause, kind);
      end
    end
    total++;
    if (div !== 32'(exp_div)) begin
      bad++;
      $display("FAIL %s divider_hold: got %0d, required %0d", name, div, exp_div);
    end
    total++;
    if (busy !== 1'b0 || busy_bad != b_busy || both_hi != b_both) begin
      bad++;
      $display("FAIL %s busy_pulse: busy=%b busy_at_pulse=%0d overlap=%0d, required 0/0/0",
               name, busy, busy_bad - b_busy, both_hi - b_both);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++;
    if ({busy, valid, err} !== 3'b000) begin
      bad++;
      $display("FAIL reset_flags: busy/valid/error=%b, required 000", {busy, valid, err});
    end
    total++;
    if (div !== 32'd0) begin
      bad++;
      $display("FAIL reset_divider: got %0d, required 0", div);
    end
    total++;
    if (cause !== 2'd0) begin
      bad++;
      $display("FAIL reset_cause: got %0d, required 0", cause);
    end
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic test_nominal();
    int dur[10];
    flat(160, dur);
    run_frame("nominal", dur, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_jitter();
    int dur[10];
    flat(160, dur);
    dur[3] = 260;
    run_frame("jitter", dur, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_frame();
    int dur[10];
    flat(160, dur);
    dur[9] = 320;
    run_frame("frame", dur, 1'b1, 1'b1, 1'b0);
  endtask

  task automatic test_range();
    int dur[10];
    flat(4, dur);
    run_frame("range", dur, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_timeout();
    int dur[10];
    int b_t;
    b_t = nerr_t;
    flat(600, dur);
    run_frame("timeout_wide", dur, 1'b0, 1'b1, 1'b0);
    total++;
    if ((nerr_t - b_t) !== 1) begin
      bad++;
      $display("FAIL timeout_pulse: error pulses=%0d, required 1", nerr_t - b_t);
    end
    total++;
    if (last_cause_t !== 0) begin
      bad++;
      $display("FAIL timeout_cause: got %0d, required 0", last_cause_t);
    end
  endtask

  task automatic test_arm_low();
    int dur[10];
    int b_p;
    b_p = nval + nerr;
    rx = 1'b0;
    repeat (10) @(posedge clk);
    arm();
    repeat (40) @(posedge clk);
    #1;
    total++;
    if (busy !== 1'b1 || (nval + nerr) != b_p) begin
      bad++;
      $display("FAIL arm_low_hold: busy=%b pulses=%0d, required busy=1 pulses=0",
               busy, nval + nerr - b_p);
    end
    rx = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    flat(100, dur);
    run_frame("arm_low", dur, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_start_busy();
    int dur[10];
    flat(120, dur);
    run_frame("start_busy", dur, 1'b0, 1'b1, 1'b1);
  endtask

  task automatic test_reset_mid();
    int b_p;
    b_p = nval + nerr;
    arm();
    rx = 1'b0; repeat (160) @(posedge clk);
    #1 rx = 1'b1; repeat (160) @(posedge clk);
    #1 rx = 1'b0; repeat (50) @(posedge clk);
    #1 rst_n = 1'b0;
    @(negedge clk);
    total++;
    if ({busy, valid, err} !== 3'b000 || div !== 32'd0 || cause !== 2'd0) begin
      bad++;
      $display("FAIL reset_mid_outputs: busy=%b valid=%b error=%b div=%0d cause=%0d, required all 0",
               busy, valid, err, div, cause);
    end
    rx = 1'b1;
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (30) @(posedge clk);
    #1;
    total++;
    if ((nval + nerr) != b_p) begin
      bad++;
      $display("FAIL reset_mid_pulse: pulses=%0d, required 0", nval + nerr - b_p);
    end
    exp_div = 0;
  endtask

  task automatic test_random();
    int dur[10];
    int b, half, mag;
    for (int it = 0; it < 8; it++) begin
      b = int'($urandom_range(300, 24));
      flat(b, dur);
      if ($urandom_range(1, 0) == 1) begin
        half = b / 2;
        if ($urandom_range(1, 0) == 1) mag = int'($urandom_range(b - 2, half + 3));
        else                           mag = int'($urandom_range(half - 3, 0));
        dur[3] = ($urandom_range(1, 0) == 1) ? b + mag : b - mag;
      end
      run_frame($sformatf("random%0d_b%0d_d3_%0d", it, b, dur[3]), dur, 1'b0, 1'b1, 1'b0);
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_jitter();
    test_frame();
    test_range();
    test_timeout();
    test_arm_low();
    test_start_busy();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
